// File: rtl/alu_pkg.sv
// Shared opcode map, scheduler state encoding and flag bundle for the
// 32-bit ALU and its front-end scheduler.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_sched_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting index at or
// after ptr, wrapping upward. The caller owns and advances ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          w_found;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      // (ptr + i) mod N without a divider; the sum never reaches 2*N.
      w_sum = {1'b0, ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
      if (enable && !w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        grant_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin front end for the shared combinational ALU: one operation in
// flight, IDLE -> EXEC -> RESP, result returned on a valid/ready channel.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,        // active-low, asynchronous
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0][31:0]   req_a,
  input  logic [NUM_REQ-1:0][31:0]   req_b,
  input  logic [NUM_REQ-1:0][3:0]    req_op,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [3:0]                 alu_op,
  input  logic [31:0]                alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_carry,
  input  logic                       alu_overflow,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_carry,
  output logic                       rsp_overflow,
  output logic                       rsp_illegal,
  output alu_sched_state_t           dbg_state,
  output logic [ID_W-1:0]            dbg_rr_ptr
);

  // Handshakes: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where rsp_valid && rsp_ready. req_ready is
  // only ever high in IDLE, and rsp_* hold stable for as long as rsp_valid is high.

  alu_sched_state_t    r_state, w_state_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [31:0]         r_a, r_b;
  logic [3:0]          r_op;
  logic [ID_W-1:0]     r_id;
  logic [31:0]         r_rsp_result;
  alu_flags_t          r_rsp_flags;
  logic                r_rsp_illegal;

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_accept;
  logic [ID_W:0]       w_ptr_inc;
  logic [ID_W-1:0]     w_ptr_next;

  // Gating with reset keeps req_ready low while reset is held.
  assign w_arb_en = (r_state == IDLE) && reset;
  assign w_accept = |w_grant;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .enable    (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_ptr_inc  = {1'b0, w_grant_idx} + (ID_W+1)'(1);
    w_ptr_next = w_ptr_inc[ID_W-1:0];
    if (w_ptr_inc >= (ID_W+1)'(NUM_REQ)) w_ptr_next = '0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = EXEC;
      EXEC:                   w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_accept) begin
        r_a      <= req_a[w_grant_idx];
        r_b      <= req_b[w_grant_idx];
        r_op     <= req_op[w_grant_idx];
        r_id     <= w_grant_idx;
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // The ALU itself reports 0 / zero=1 for undefined opcodes; we only tag them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_result  <= alu_result;
      r_rsp_flags   <= '{zero: alu_zero, carry: alu_carry, overflow: alu_overflow};
      r_rsp_illegal <= (r_op > OP_LAST);
    end
  end

  assign req_ready    = w_grant;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign rsp_valid    = (r_state == RESP);
  assign rsp_id       = r_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_flags.zero;
  assign rsp_carry    = r_rsp_flags.carry;
  assign rsp_overflow = r_rsp_flags.overflow;
  assign rsp_illegal  = r_rsp_illegal;
  assign dbg_state    = r_state;
  assign dbg_rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with NUM_REQ=2 and a behavioural ALU;
// table of single operations plus hand sequences for multi-cycle corners.
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a = '0;
  logic [NUM_REQ-1:0][31:0] req_b = '0;
  logic [NUM_REQ-1:0][3:0]  req_op = '0;
  logic [31:0]              alu_a, alu_b;
  logic [3:0]               alu_op;
  logic [31:0]              alu_result;
  logic                     alu_zero, alu_carry, alu_overflow;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_result;
  logic                     rsp_zero, rsp_carry, rsp_overflow, rsp_illegal;
  alu_sched_state_t         dbg_state;
  logic [ID_W-1:0]          dbg_rr_ptr;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  alu_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .dbg_state    (dbg_state),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  // Behavioural stand-in for the shared ALU.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_sum[31:0];
        alu_carry    = alu_sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOT: alu_result = ~alu_a;
      OP_SLL: alu_result = alu_a << alu_b[4:0];
      OP_SRL: alu_result = alu_a >> alu_b[4:0];
      OP_SAR: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_ovf;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One full transaction on an otherwise quiet bus with rsp_ready high.
  task automatic run_vec(input vec_t v);
    @(negedge clock);
    rsp_ready        = 1'b1;
    req_a[v.id]      = v.a;
    req_b[v.id]      = v.b;
    req_op[v.id]     = v.op;
    req_valid        = '0;
    req_valid[v.id]  = 1'b1;
    #1;
    chk("vec_idle_state", 32'(dbg_state), 32'(IDLE));
    chk("vec_req_ready", 32'(req_ready), 32'(1 << v.id));
    @(negedge clock);
    req_valid = '0;
    chk("vec_exec_state", 32'(dbg_state), 32'(EXEC));
    chk("vec_alu_a", alu_a, v.a);
    chk("vec_alu_op", 32'(alu_op), 32'(v.op));
    chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
    chk("vec_rsp_result", rsp_result, v.exp_result);
    chk("vec_rsp_zero", 32'(rsp_zero), 32'(v.exp_zero));
    chk("vec_rsp_carry", 32'(rsp_carry), 32'(v.exp_carry));
    chk("vec_rsp_overflow", 32'(rsp_overflow), 32'(v.exp_ovf));
    chk("vec_rsp_illegal", 32'(rsp_illegal), 32'(v.exp_illegal));
    @(negedge clock);
    chk("vec_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("vec_back_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    //          id  a              b              op      result         z     c     v     ill
    vecs[0]  = '{0, 32'd5,         32'd3,         OP_ADD, 32'd8,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1, 32'd1,         32'd1,         OP_SUB, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 32'd0,         32'd1,         OP_SUB, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1, 32'h7FFFFFFF,  32'd1,         OP_ADD, 32'h80000000,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 32'hFFFFFFFF,  32'd1,         OP_ADD, 32'd0,         1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1, 32'hF0F0F0F0,  32'hFF00FF00,  OP_AND, 32'hF000F000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{0, 32'h0000000F,  32'h000000F0,  OP_OR,  32'h000000FF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 32'hAAAA5555,  32'hFFFF0000,  OP_XOR, 32'h55555555,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{0, 32'd0,         32'd7,         OP_NOT, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 32'd1,         32'd31,        OP_SLL, 32'h80000000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{0, 32'h80000000,  32'd4,         OP_SRL, 32'h08000000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1, 32'h80000000,  32'd31,        OP_SAR, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{0, 32'h0000FFFF,  32'h0000FFFF,  4'hF,   32'd0,         1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values, with both requesters asking while reset is held.
    req_valid = 2'b11;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_zero, rsp_carry, rsp_overflow}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles with another requester waiting.
    @(negedge clock);
    rsp_ready  = 1'b0;
    req_a[1]   = 32'h7FFFFFFF;
    req_b[1]   = 32'd1;
    req_op[1]  = OP_ADD;
    req_valid  = 2'b10;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'b10);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    req_a[0]  = 32'd9;
    req_b[0]  = 32'd9;
    req_op[0] = OP_ADD;
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_state", 32'(dbg_state), 32'(RESP));
      chk("bp_rsp_result", rsp_result, 32'h80000000);
      chk("bp_rsp_overflow", 32'(rsp_overflow), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clock);
    #1;
    chk("bp_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("bp_back_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset in EXEC: operation dropped, pointer returns to 0.
    @(negedge clock);
    req_a[0]  = 32'd5;
    req_b[0]  = 32'd3;
    req_op[0] = OP_ADD;
    req_valid = 2'b01;
    #1;
    chk("mid_req_ready", 32'(req_ready), 32'b01);
    @(negedge clock);
    chk("mid_exec_state", 32'(dbg_state), 32'(EXEC));
    chk("mid_ptr_before", 32'(dbg_rr_ptr), 32'd1);
    reset     = 1'b0;
    req_a     = '{32'd0, 32'd1};
    req_b     = '{32'd1, 32'd1};
    req_op    = '{OP_SUB, OP_SUB};
    req_valid = 2'b11;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_alu_a", alu_a, 32'd0);
    chk("mid_alu_b", alu_b, 32'd0);
    chk("mid_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    chk("mid_hold_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    #1;

    // Contention: both held, grants alternate starting at requester 0.
    for (int g = 0; g < 4; g++) begin
      int w = 0;
      while (req_ready == '0 && w < 8) begin
        @(negedge clock);
        #1;
        w++;
      end
      chk("cont_grant_timeout", 32'(w < 8), 32'd1);
      chk("cont_grant", 32'(req_ready), (g % 2 == 0) ? 32'b01 : 32'b10);
      @(negedge clock);
      @(negedge clock);
      chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("cont_rsp_id", 32'(rsp_id), 32'(g % 2));
      chk("cont_rsp_result", rsp_result, (g % 2 == 0) ? 32'd0 : 32'hFFFFFFFF);
      chk("cont_rsp_zero", 32'(rsp_zero), (g % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_rsp_carry", 32'(rsp_carry), (g % 2 == 0) ? 32'd0 : 32'd1);
      @(negedge clock);
      #1;
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Multi-requester front end for the shared 32-bit ALU. Arbitrates up to NUM_REQ command sources (SPI command decoder, microsequencer, debug port) with a round-robin policy. Launches one operation at a time into the combinational ALU and returns the registered result, flags and requester ID over a valid/ready response channel.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4.
- ID_W, $clog2(NUM_REQ): requester ID width.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clock.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ×32  operand A per requester.
- req_b  in  NUM_REQ×32  operand B per requester.
- req_op  in  NUM_REQ×4  opcode per requester.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  4  ALU opcode.
- alu_result  in  32  ALU result, combinational from alu_*.
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that issued the command.
- rsp_result  out  32  captured result.
- rsp_zero, rsp_carry, rsp_overflow  out  1 each  captured flags.
- rsp_illegal  out  1  opcode was outside 0..8.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - Assert req_ready for the granted requester only, combinationally in this cycle.
  - On the edge, latch a, b, op and ID into the operand registers; go to EXEC.
  - Update rr_ptr to (granted index + 1) mod NUM_REQ.
- EXEC:
  - alu_a, alu_b, alu_op are driven from the operand registers.
  - At the end of the cycle, capture alu_result and flags into the response registers.
  - Set rsp_illegal = (op > 4'd8). Result and flags are captured as the ALU presents them (0 and zero=1 for illegal opcodes).
  - Go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No new grant in the same cycle; the next grant is possible one cycle later.
- alu_* outputs hold the operand registers in every state; they are zero after reset.
- req_ready is 0 in EXEC and RESP.
- A requester that drops req_valid before being granted loses nothing; no request is queued internally.
- A requester holding req_valid is served within NUM_REQ grants (starvation-free).

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0 while reset is asserted.
  - rsp_valid=0, rsp_id=0, rsp_result=0, all rsp flags=0.
  - alu_a=0, alu_b=0, alu_op=0.
- Latency: grant at edge N. EXEC occupies cycle N..N+1. rsp_valid is high from edge N+1 (captured at the end of EXEC) onward.
  - Concretely: accept edge E0, capture edge E1, rsp_valid visible after E1.
- Throughput with rsp_ready tied high: one operation per 3 cycles (IDLE, EXEC, RESP).
- Simultaneous req_valid on all lines: exactly one req_ready per grant, following rotating priority.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset asserted mid-EXEC or mid-RESP: the operation is discarded; there is no response and no req_ready afterwards until re-requested.
- ALU path: one full cycle from operand registers through the ALU to the response registers.

## Structure
- Shared package alu_pkg:
  - OP_ADD..OP_SAR opcode localparams (4'b0000..4'b1000).
  - OP_LAST = 4'd8.
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_sched_state_t.
  - alu_flags_t struct {zero, carry, overflow}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and grant_idx.
  - Purely combinational; the scheduler owns rr_ptr.
- Top level holds the FSM, operand registers and response registers. Testbench instantiates the existing ALU for alu_*.

## Test plan
- Single request: requester 0 sends a=5, b=3, op=ADD with rsp_ready=1. Required: req_ready[0] for 1 cycle; rsp_valid 1 cycle after accept; rsp_result=8, rsp_id=0, all flags 0.
- Contention, NUM_REQ=2: both requesters hold req_valid with SUB operands 1−1 and 0−1. Required: grants alternate 0,1,0,1; id0 gives result=0, zero=1; id1 gives 0xFFFFFFFF, carry=1.
- Backpressure: rsp_ready=0 for 5 cycles after an ADD of 0x7FFFFFFF+1. Required: rsp_result=0x80000000 and overflow=1 held stable; req_ready stays 0; IDLE is re-entered the cycle after rsp_ready rises.
- Illegal opcode: op=4'hF, a=b=0xFFFF. Required: rsp_illegal=1, rsp_result=0, rsp_zero=1.
- Reset mid-operation: pull reset low during EXEC, then release. Required: rsp_valid=0, alu_*=0, rr_ptr=0; the next simultaneous request is granted to requester 0.
- Shift boundary: SAR with a=0x80000000, b=31. Required: result 0xFFFFFFFF, carry=0, overflow=0.
